// File: rtl/prewish.sv
// -----------------------------------------------------------------------------
// prewish: iCE40 demo that blinks one LED with a repeating 8-step pattern.
//
// Modules in this file:
//   prewish_syscon  - system clock buffer and power-on reset generator
//     i_clk  in  raw board clock
//     CLK_O  out system clock (i_clk through a global buffer)
//     RST_O  out synchronous active-high reset, high for RESET_CYCLES edges
//   prewish_mentor  - issues one write strobe carrying INIT_MASK after reset
//     CLK_I  in  system clock
//     RST_I  in  synchronous active-high reset
//     STB_O  out one-cycle write strobe
//     DAT_O  out pattern byte (zero except during the strobe)
//   prewish_blinky  - stores the pattern and plays it MSB first
//     CLK_I  in  system clock
//     RST_I  in  synchronous active-high reset
//     STB_I  in  write strobe
//     DAT_I  in  pattern byte
//     o_led  out LED, active high
//   prewish         - top level wiring the three together
//     i_clk  in  raw board clock
//     o_led  out LED, active high
//     o_rst  out system reset (observation)
//     o_stb  out mentor strobe (observation)
//     o_dat  out mentor data (observation)
// -----------------------------------------------------------------------------

module prewish_syscon #(
   parameter int unsigned RESET_CYCLES = 8
) (
   input  logic i_clk,
   output logic CLK_O,
   output logic RST_O
);

   localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   // Power-on values come from the FPGA configuration bitstream; there is no
   // reset input to this block because it is the reset source.
   logic [CNT_W-1:0] r_cnt = '0;
   logic             r_rst = 1'b1;
   logic             w_clk;

`ifdef SYNTHESIS
   SB_GB u_gb (
      .USER_SIGNAL_TO_GLOBAL_BUFFER (i_clk),
      .GLOBAL_BUFFER_OUTPUT         (w_clk)
   );
`else
   assign w_clk = i_clk;
`endif

   assign CLK_O = w_clk;

   // r_cnt counts completed reset edges; reset drops on edge RESET_CYCLES.
   always_ff @(posedge w_clk) begin
      if (r_rst) begin
         if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            r_rst <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign RST_O = r_rst;

endmodule

module prewish_mentor #(
   parameter int unsigned STROBE_DELAY = 4,   // must be at least 1
   parameter logic [7:0]  INIT_MASK    = 8'hA5
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   output logic       STB_O,
   output logic [7:0] DAT_O
);

   localparam int unsigned CNT_W = (STROBE_DELAY > 1) ? $clog2(STROBE_DELAY) : 1;

   typedef enum logic [0:0] {StCount, StDone} state_e;

   state_e           r_state;
   state_e           w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stb;
   logic [7:0]       r_dat;
   logic             w_hit;
   logic             w_stb_d;

   // Strobe is registered on the edge where the count reaches STROBE_DELAY-1,
   // so it is visible during cycle STROBE_DELAY after reset release.
   assign w_hit = (r_cnt == CNT_W'(STROBE_DELAY - 1));

   // State register, count and registered outputs.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state <= StCount;
         r_cnt   <= '0;
         r_stb   <= 1'b0;
         r_dat   <= 8'h00;
      end else begin
         r_state <= w_state_d;
         r_stb   <= w_stb_d;
         r_dat   <= w_stb_d ? INIT_MASK : 8'h00;
         if (r_state == StCount && !w_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StCount: if (w_hit) w_state_d = StDone;
         StDone:  w_state_d = StDone;
         default: w_state_d = StCount;
      endcase
   end

   // Output logic (next value of the registered strobe).
   always_comb begin
      w_stb_d = 1'b0;
      unique case (r_state)
         StCount: w_stb_d = w_hit;
         StDone:  w_stb_d = 1'b0;
         default: w_stb_d = 1'b0;
      endcase
   end

   assign STB_O = r_stb;
   assign DAT_O = r_dat;

endmodule

module prewish_blinky #(
   parameter int unsigned SYSCLK_DIV_BITS = 22
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       STB_I,
   input  logic [7:0] DAT_I,
   output logic       o_led
);

   localparam logic [SYSCLK_DIV_BITS-1:0] PRESC_ONE = SYSCLK_DIV_BITS'(1);

   logic [7:0]                 r_mask;
   logic [2:0]                 r_idx;
   logic [SYSCLK_DIV_BITS-1:0] r_presc;
   logic                       r_led;
   logic                       w_presc_wrap;

   assign w_presc_wrap = &r_presc;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_mask  <= 8'h00;
         r_idx   <= 3'd7;
         r_presc <= '0;
         r_led   <= 1'b0;
      end else begin
         // Uses pre-update mask/idx, so a new pattern shows one edge later.
         r_led <= r_mask[r_idx];
         if (STB_I) begin
            r_mask  <= DAT_I;
            r_idx   <= 3'd7;
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PRESC_ONE;
            if (w_presc_wrap) begin
               r_idx <= r_idx - 3'd1;   // wraps 0 -> 7
            end
         end
      end
   end

   assign o_led = r_led;

endmodule

module prewish #(
   parameter int unsigned SYSCLK_DIV_BITS = 22,
   parameter int unsigned RESET_CYCLES    = 8,
   parameter int unsigned STROBE_DELAY    = 4,
   parameter logic [7:0]  INIT_MASK       = 8'hA5
) (
   input  logic       i_clk,
   output logic       o_led,
   output logic       o_rst,
   output logic       o_stb,
   output logic [7:0] o_dat
);

   logic       w_clk;
   logic       w_rst;
   logic       w_stb;
   logic [7:0] w_dat;

   prewish_syscon #(
      .RESET_CYCLES (RESET_CYCLES)
   ) u_syscon (
      .i_clk (i_clk),
      .CLK_O (w_clk),
      .RST_O (w_rst)
   );

   prewish_mentor #(
      .STROBE_DELAY (STROBE_DELAY),
      .INIT_MASK    (INIT_MASK)
   ) u_mentor (
      .CLK_I (w_clk),
      .RST_I (w_rst),
      .STB_O (w_stb),
      .DAT_O (w_dat)
   );

   prewish_blinky #(
      .SYSCLK_DIV_BITS (SYSCLK_DIV_BITS)
   ) u_blinky (
      .CLK_I (w_clk),
      .RST_I (w_rst),
      .STB_I (w_stb),
      .DAT_I (w_dat),
      .o_led (o_led)
   );

   assign o_rst = w_rst;
   assign o_stb = w_stb;
   assign o_dat = w_dat;

endmodule

// File: tb/tb_prewish.sv
// -----------------------------------------------------------------------------
// tb_prewish: directed bench for the prewish top (reset, mentor strobe,
// end-to-end playback) plus a standalone blinky for strobe/reset corner cases.
// -----------------------------------------------------------------------------
module tb_prewish;

   logic       clk = 1'b0;
   logic       led;
   logic       rst;
   logic       stb;
   logic [7:0] dat;

   logic       b_rst = 1'b1;
   logic       b_stb = 1'b0;
   logic [7:0] b_dat = 8'h00;
   logic       b_led;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prewish #(
      .SYSCLK_DIV_BITS (3),
      .RESET_CYCLES    (8),
      .STROBE_DELAY    (4),
      .INIT_MASK       (8'hA5)
   ) u_dut (
      .i_clk (clk),
      .o_led (led),
      .o_rst (rst),
      .o_stb (stb),
      .o_dat (dat)
   );

   prewish_blinky #(
      .SYSCLK_DIV_BITS (3)
   ) u_blk (
      .CLK_I (clk),
      .RST_I (b_rst),
      .STB_I (b_stb),
      .DAT_I (b_dat),
      .o_led (b_led)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] pat;
   int         bitpos;

   initial begin
      pat = 8'hA5;

      // Power-on state before the first edge.
      #1;
      chk("por_rst", {31'b0, rst}, 32'd1);
      chk("por_stb", {31'b0, stb}, 32'd0);
      chk("por_led", {31'b0, led}, 32'd0);

      // Reset is high through edge 7, low from edge 8; strobe after edge 12;
      // LED plays A5 from edge 14, 8 clocks per bit, 64-clock period.
      for (int k = 1; k <= 14 + 64 * 3 + 8; k++) begin
         step();
         chk("rst", {31'b0, rst}, (k < 8) ? 32'd1 : 32'd0);
         chk("stb", {31'b0, stb}, (k == 12) ? 32'd1 : 32'd0);
         chk("dat", {24'b0, dat}, (k == 12) ? 32'hA5 : 32'h0);
         if (k < 14) begin
            chk("led_pre", {31'b0, led}, 32'd0);
         end else begin
            bitpos = 7 - (((k - 14) / 8) % 8);
            chk("led_play", {31'b0, led}, {31'b0, pat[bitpos]});
         end
      end

      // Standalone blinky: mid-pattern strobe.
      b_rst = 1'b1;
      step();
      step();
      chk("blk_rst_led", {31'b0, b_led}, 32'd0);
      b_rst = 1'b0;
      b_stb = 1'b1;
      b_dat = 8'h0F;
      step();                       // strobe edge S
      b_stb = 1'b0;
      b_dat = 8'h00;
      for (int j = 1; j <= 32; j++) begin
         step();
         // bits 7..4 of 0F are all zero
         chk("blk_0f_hi", {31'b0, b_led}, 32'd0);
      end
      b_stb = 1'b1;                 // idx is 3 now
      b_dat = 8'hF0;
      step();
      b_stb = 1'b0;
      b_dat = 8'h00;
      chk("blk_mid_old", {31'b0, b_led}, 32'd1);   // 0F[3]
      for (int i = 1; i <= 64; i++) begin
         step();
         chk("blk_mid_f0", {31'b0, b_led}, (i <= 32) ? 32'd1 : 32'd0);
      end

      // Reset mid-operation, with a simultaneous strobe that must be ignored.
      b_stb = 1'b1;
      b_dat = 8'hFF;
      step();
      b_stb = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("blk_ff_on", {31'b0, b_led}, 32'd1);
      end
      b_rst = 1'b1;
      b_stb = 1'b1;
      b_dat = 8'hFF;
      step();
      chk("blk_rst_now", {31'b0, b_led}, 32'd0);
      b_rst = 1'b0;
      b_stb = 1'b0;
      b_dat = 8'h00;
      for (int i = 1; i <= 70; i++) begin
         step();
         chk("blk_rst_hold", {31'b0, b_led}, 32'd0);
      end

      // Edge patterns.
      b_stb = 1'b1;
      b_dat = 8'h00;
      step();
      b_stb = 1'b0;
      for (int i = 1; i <= 70; i++) begin
         step();
         chk("blk_00", {31'b0, b_led}, 32'd0);
      end
      b_stb = 1'b1;
      b_dat = 8'hFF;
      step();
      b_stb = 1'b0;
      b_dat = 8'h00;
      for (int i = 1; i <= 70; i++) begin
         step();
         chk("blk_ff", {31'b0, b_led}, 32'd1);
      end
      b_stb = 1'b1;
      b_dat = 8'h01;
      step();
      b_stb = 1'b0;
      b_dat = 8'h00;
      for (int j = 1; j <= 130; j++) begin
         step();
         // bit 0 plays during edges 57..64 of each 64-edge period
         chk("blk_01", {31'b0, b_led}, ((((j - 1) / 8) % 8) == 7) ? 32'd1 : 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
